// File: rtl/idli_sqi_ctrl_m_if.sv
// idli_sqi_ctrl_m_if: core-side and SQI-pad-side signal bundle for the
// quad-mode SRAM controller, plus the nibble datapath type it carries.
// slave  = the controller's view, master = the core/pad side view.
package idli_sqi_pkg;
  typedef logic [3:0] sqi_data_t;
endpackage

interface idli_sqi_ctrl_m_if;
  import idli_sqi_pkg::*;

  // core request / data handshake
  logic        i_sqi_req;
  logic        i_sqi_wr;
  logic [15:0] i_sqi_addr;
  logic        o_sqi_ack;
  logic        i_sqi_stop;
  sqi_data_t   o_sqi_rd_data;
  logic        o_sqi_rd_vld;
  sqi_data_t   i_sqi_wr_data;
  logic        o_sqi_wr_rdy;
  // SRAM pads
  logic        o_sqi_cs_n;
  logic        o_sqi_sck_en;
  logic [3:0]  o_sqi_sio_out;
  logic        o_sqi_sio_oe;
  logic [3:0]  i_sqi_sio_in;

  modport slave (
    input  i_sqi_req, i_sqi_wr, i_sqi_addr, i_sqi_stop, i_sqi_wr_data, i_sqi_sio_in,
    output o_sqi_ack, o_sqi_rd_data, o_sqi_rd_vld, o_sqi_wr_rdy,
           o_sqi_cs_n, o_sqi_sck_en, o_sqi_sio_out, o_sqi_sio_oe
  );

  modport master (
    output i_sqi_req, i_sqi_wr, i_sqi_addr, i_sqi_stop, i_sqi_wr_data, i_sqi_sio_in,
    input  o_sqi_ack, o_sqi_rd_data, o_sqi_rd_vld, o_sqi_wr_rdy,
           o_sqi_cs_n, o_sqi_sck_en, o_sqi_sio_out, o_sqi_sio_oe
  );
endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: nibble-serial controller for a quad-mode SQI SRAM.
// Sequence: IDLE -> INSTR(2) -> ADDR(6) -> [DUMMY(2) on reads] -> DATA -> DESEL(1).
// Optional macro IDLI_SQI_WORD_BURST_EN: DATA ends after exactly 4 nibbles
// (one 16b word) and i_sqi_stop is ignored; otherwise DATA ends on i_sqi_stop.
module idli_sqi_ctrl_m
  import idli_sqi_pkg::*;
(
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  idli_sqi_ctrl_m_if.slave  sqi
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INSTR = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DESEL = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;

  logic        data_last;
  logic [31:0] hdr_w;
  logic [2:0]  hdr_idx;
  logic [3:0]  hdr_nib;

`ifdef IDLI_SQI_WORD_BURST_EN
  // DATA phase position within the 16b word; the 4th nibble closes the burst.
  logic [1:0] word_cnt;
  assign word_cnt  = cnt_q[1:0];
  assign data_last = (word_cnt == 2'd3);
`else
  assign data_last = sqi.i_sqi_stop;
`endif

  // Instruction byte followed by the 24b address, shifted out MSB nibble first.
  assign hdr_w   = {(wr_q ? 8'h02 : 8'h03), 8'h00, addr_q};
  assign hdr_idx = (state_q == ST_ADDR) ? (cnt_q + 3'd2) : cnt_q;
  assign hdr_nib = hdr_w[5'd28 - {hdr_idx, 2'b00} +: 4];

  // Next-state logic: phase sequencing and request capture.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (sqi.i_sqi_req) begin
          state_d = ST_INSTR;
          wr_d    = sqi.i_sqi_wr;
          addr_d  = sqi.i_sqi_addr;
        end
      end
      ST_INSTR: if (cnt_q == 3'd1) state_d = ST_ADDR;
      ST_ADDR:  if (cnt_q == 3'd5) state_d = wr_q ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (cnt_q == 3'd1) state_d = ST_DATA;
      ST_DATA:  if (data_last)     state_d = ST_DESEL;
      ST_DESEL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // The phase counter restarts at every state change.
    cnt_d = (state_d != state_q) ? 3'd0 : (cnt_q + 3'd1);
  end

  // State registers with synchronous active-low reset (no DESEL on abort).
  always_ff @(posedge i_sqi_gck) begin
    if (!i_sqi_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

  // Output decode from the current phase; data paths are combinational pass-through.
  always_comb begin
    sqi.o_sqi_ack     = 1'b0;
    sqi.o_sqi_rd_vld  = 1'b0;
    sqi.o_sqi_rd_data = 4'h0;
    sqi.o_sqi_wr_rdy  = 1'b0;
    sqi.o_sqi_cs_n    = 1'b1;
    sqi.o_sqi_sck_en  = 1'b0;
    sqi.o_sqi_sio_out = 4'h0;
    sqi.o_sqi_sio_oe  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so every output is quiet in reset.
        sqi.o_sqi_ack = sqi.i_sqi_req & i_sqi_rst_n;
      end
      ST_INSTR, ST_ADDR: begin
        sqi.o_sqi_cs_n    = 1'b0;
        sqi.o_sqi_sck_en  = 1'b1;
        sqi.o_sqi_sio_oe  = 1'b1;
        sqi.o_sqi_sio_out = hdr_nib;
      end
      ST_DUMMY: begin
        sqi.o_sqi_cs_n   = 1'b0;
        sqi.o_sqi_sck_en = 1'b1;
      end
      ST_DATA: begin
        sqi.o_sqi_cs_n   = 1'b0;
        sqi.o_sqi_sck_en = 1'b1;
        if (wr_q) begin
          sqi.o_sqi_sio_oe  = 1'b1;
          sqi.o_sqi_sio_out = sqi.i_sqi_wr_data;
          sqi.o_sqi_wr_rdy  = 1'b1;
        end else begin
          sqi.o_sqi_rd_vld  = 1'b1;
          sqi.o_sqi_rd_data = sqi.i_sqi_sio_in;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: directed stimulus with a per-cycle expected-output
// scoreboard; a negedge monitor pops and compares independently of the driver.
module tb_idli_sqi_ctrl_m;
  import idli_sqi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idli_sqi_ctrl_m_if bus();

  idli_sqi_ctrl_m dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .sqi         (bus)
  );

  typedef struct packed {
    logic       ack;
    logic       cs_n;
    logic       sck_en;
    logic       oe;
    logic [3:0] so;
    logic       rv;
    logic [3:0] rd;
    logic       wr_rdy;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  // Monitor: outputs are compared mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      cmp("ack",     {3'b0, bus.o_sqi_ack},    {3'b0, x.ack});
      cmp("cs_n",    {3'b0, bus.o_sqi_cs_n},   {3'b0, x.cs_n});
      cmp("sck_en",  {3'b0, bus.o_sqi_sck_en}, {3'b0, x.sck_en});
      cmp("sio_oe",  {3'b0, bus.o_sqi_sio_oe}, {3'b0, x.oe});
      cmp("sio_out", bus.o_sqi_sio_out,        x.so);
      cmp("rd_vld",  {3'b0, bus.o_sqi_rd_vld}, {3'b0, x.rv});
      cmp("wr_rdy",  {3'b0, bus.o_sqi_wr_rdy}, {3'b0, x.wr_rdy});
      if (x.rv) cmp("rd_data", bus.o_sqi_rd_data, x.rd);
    end
  end

  function automatic exp_t mk(logic ack, logic csn, logic sck, logic oe, logic [3:0] so,
                              logic rv, logic [3:0] rd, logic wr);
    return {ack, csn, sck, oe, so, rv, rd, wr};
  endfunction
  function automatic exp_t e_idle(logic ack);    return mk(ack, 1, 0, 0, 4'h0, 0, 4'h0, 0); endfunction
  function automatic exp_t e_desel();            return mk(0,   1, 0, 0, 4'h0, 0, 4'h0, 0); endfunction
  function automatic exp_t e_drv(logic [3:0] n); return mk(0,   0, 1, 1, n,    0, 4'h0, 0); endfunction
  function automatic exp_t e_dummy();            return mk(0,   0, 1, 0, 4'h0, 0, 4'h0, 0); endfunction
  function automatic exp_t e_rd(logic [3:0] n);  return mk(0,   0, 1, 0, 4'h0, 1, n,    0); endfunction
  function automatic exp_t e_wr(logic [3:0] n);  return mk(0,   0, 1, 1, n,    0, 4'h0, 1); endfunction

  // One clock cycle: queue the expectation for the inputs currently applied.
  task automatic step(input exp_t x, input bit chk);
    if (chk) exp_q.push_back(x);
    @(posedge clk);
    #1;
    bus.i_sqi_req  = 1'b0;
    bus.i_sqi_stop = 1'b0;
  endtask

  task automatic accept(input bit wr, input logic [15:0] a);
    bus.i_sqi_req  = 1'b1;
    bus.i_sqi_wr   = wr;
    bus.i_sqi_addr = a;
    step(e_idle(1'b1), 1'b1);
  endtask

  // Instruction + address phases; core inputs are scrambled to prove latching.
  task automatic hdr(input bit wr, input logic [15:0] a, input bit hold_req);
    logic [31:0] w;
    w = {(wr ? 8'h02 : 8'h03), 8'h00, a};
    for (int i = 0; i < 8; i++) begin
      bus.i_sqi_addr   = 16'hDEAD;
      bus.i_sqi_wr     = ~wr;
      bus.i_sqi_req    = hold_req;
      bus.i_sqi_stop   = (i == 4);
      bus.i_sqi_sio_in = 4'h7;
      step(e_drv(w[31-4*i -: 4]), 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] n;
    logic [3:0] abort_nib [5];
    bus.i_sqi_req     = 1'b0;
    bus.i_sqi_wr      = 1'b0;
    bus.i_sqi_addr    = 16'h0000;
    bus.i_sqi_stop    = 1'b0;
    bus.i_sqi_wr_data = 4'h0;
    bus.i_sqi_sio_in  = 4'h0;
    @(posedge clk);
    #1;

    // Reset held two cycles; second cycle checked (req high must not ack).
    $display("TXN reset");
    step(e_idle(1'b0), 1'b0);
    bus.i_sqi_req = 1'b1;
    step(e_idle(1'b0), 1'b1);
    rst_n = 1'b1;
    step(e_idle(1'b0), 1'b1);

    // Read 0x1234, four nibbles A..D, stop on the 4th.
    $display("TXN read addr=1234 nibbles=A,B,C,D");
    accept(1'b0, 16'h1234);
    hdr(1'b0, 16'h1234, 1'b0);
    bus.i_sqi_stop = 1'b1;
    step(e_dummy(), 1'b1);
    step(e_dummy(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      n = 4'hA + 4'(i);
      bus.i_sqi_sio_in = n;
      bus.i_sqi_stop   = (i == 3);
      step(e_rd(n), 1'b1);
    end
    bus.i_sqi_req = 1'b1;
    step(e_desel(), 1'b1);
    step(e_idle(1'b0), 1'b1);

    // Write 0xFFFE, two nibbles of 5, stop on the 2nd.
    $display("TXN write addr=FFFE nibbles=5,5");
    accept(1'b1, 16'hFFFE);
    bus.i_sqi_wr_data = 4'h5;
    hdr(1'b1, 16'hFFFE, 1'b0);
    step(e_wr(4'h5), 1'b1);
    bus.i_sqi_stop = 1'b1;
    step(e_wr(4'h5), 1'b1);
    step(e_desel(), 1'b1);
    step(e_idle(1'b0), 1'b1);

    // Back-to-back: req held high, single-nibble write, next ack two cycles after stop.
    $display("TXN write addr=00A5 nibble=9 with req held high");
    accept(1'b1, 16'h00A5);
    bus.i_sqi_wr_data = 4'h9;
    hdr(1'b1, 16'h00A5, 1'b1);
    bus.i_sqi_req  = 1'b1;
    bus.i_sqi_stop = 1'b1;
    step(e_wr(4'h9), 1'b1);
    bus.i_sqi_req = 1'b1;
    step(e_desel(), 1'b1);

    // Read 0x5A00 aborted by reset in its cycle 5 (third address nibble).
    $display("TXN read addr=5A00 aborted by reset in cycle 5");
    accept(1'b0, 16'h5A00);
    abort_nib[0] = 4'h0; abort_nib[1] = 4'h3; abort_nib[2] = 4'h0;
    abort_nib[3] = 4'h0; abort_nib[4] = 4'h5;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rst_n = 1'b0;
      step(e_drv(abort_nib[i]), 1'b1);
    end
    rst_n = 1'b1;

    // Fresh read 0x0001 restarts at INSTR; stop held low to probe burst length.
    $display("TXN read addr=0001 stop held low");
    accept(1'b0, 16'h0001);
    hdr(1'b0, 16'h0001, 1'b0);
    step(e_dummy(), 1'b1);
    step(e_dummy(), 1'b1);
`ifdef IDLI_SQI_WORD_BURST_EN
    for (int i = 0; i < 4; i++) begin
      n = 4'(i + 1);
      bus.i_sqi_sio_in = n;
      step(e_rd(n), 1'b1);
    end
`else
    for (int i = 0; i < 10; i++) begin
      n = 4'(i + 1);
      bus.i_sqi_sio_in = n;
      bus.i_sqi_stop   = (i == 9);
      step(e_rd(n), 1'b1);
    end
`endif
    step(e_desel(), 1'b1);
    step(e_idle(1'b0), 1'b1);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl_m.md
# idli_sqi_ctrl_m

Nibble-serial controller for an external SQI SRAM operating in quad mode. The core issues a 16b address and a direction. The block emits the instruction and address phases on the 4b SIO bus. It then streams data nibbles between the SIO pins and the core's `sqi_data_t` datapath, one nibble per cycle, until the core ends the burst. It is the memory-side counterpart of the nibble-rotating register file: it sources and sinks the 4b slices that the core datapath consumes and produces each cycle.

## Interface
Parameters: none.

Ports:
- `i_sqi_gck` in 1 — clock; single clock domain.
- `i_sqi_rst_n` in 1 — reset; synchronous, active-low.
- `i_sqi_req` in 1 — start a transaction.
- `i_sqi_wr` in 1 — direction of the request: 1 = write, 0 = read.
- `i_sqi_addr` in 16 — transaction start address.
- `o_sqi_ack` out 1 — request accepted this cycle.
- `i_sqi_stop` in 1 — current data cycle is the last one of the burst.
- `o_sqi_rd_data` out `sqi_data_t` — read nibble.
- `o_sqi_rd_vld` out 1 — `o_sqi_rd_data` is valid.
- `i_sqi_wr_data` in `sqi_data_t` — write nibble.
- `o_sqi_wr_rdy` out 1 — `i_sqi_wr_data` is consumed this cycle.
- `o_sqi_cs_n` out 1 — SRAM chip select.
- `o_sqi_sck_en` out 1 — SRAM clock enable; the pad gates `i_sqi_gck` with it.
- `o_sqi_sio_out` out 4 — SIO drive value.
- `o_sqi_sio_oe` out 1 — SIO output enable.
- `i_sqi_sio_in` in 4 — SIO sampled value.

## Operation
- FSM states: IDLE, INSTR, ADDR, DUMMY, DATA, DESEL.
- **IDLE**
  - `o_sqi_ack` = `i_sqi_req`, combinational.
  - On accept, latch `i_sqi_wr` and `i_sqi_addr`, then go to INSTR.
- **INSTR**, 2 cycles
  - Drives the instruction MSB nibble first.
  - Instruction is 8'h03 for a read, 8'h02 for a write.
- **ADDR**, 6 cycles
  - Drives the 24b value {8'h00, addr}, MSB nibble first.
  - Next state is DUMMY for a read, DATA for a write.
- **DUMMY**, 2 cycles, read only
  - `o_sqi_sio_oe` = 0.
- **DATA**
  - Read: `o_sqi_sio_oe` = 0, `o_sqi_rd_vld` = 1, `o_sqi_rd_data` = `i_sqi_sio_in`.
  - Write: `o_sqi_sio_oe` = 1, `o_sqi_sio_out` = `i_sqi_wr_data`, `o_sqi_wr_rdy` = 1.
  - Stays in DATA while `i_sqi_stop` = 0.
  - When `i_sqi_stop` = 1, the current nibble is the last one and the next state is DESEL.
- **DESEL**, 1 cycle
  - `o_sqi_cs_n` = 1. Requests are not accepted here.
  - Next state is IDLE.
- `o_sqi_cs_n` = 0 and `o_sqi_sck_en` = 1 in INSTR, ADDR, DUMMY and DATA only.
- Phase nibble counter is 3b. It clears on every state change.
- `o_sqi_sio_oe` = 1 in INSTR, ADDR, and DATA on a write only.
- `o_sqi_sio_out` = 4'h0 whenever `o_sqi_sio_oe` = 0.
- Reset values: state IDLE, `o_sqi_cs_n` = 1, and every other output 0, including `o_sqi_sio_out` = 4'h0.

## Timing
- Request accepted in cycle 0 (IDLE with `i_sqi_req` = 1).
- Cycles 1–2: INSTR.
- Cycles 3–8: ADDR.
- Read: cycles 9–10 DUMMY; first read nibble in cycle 11.
- Write: first write nibble consumed in cycle 9.
- A stop in cycle N gives DESEL in cycle N+1 and IDLE in cycle N+2.
- Earliest next accept is in cycle N+2.
- `i_sqi_stop` is ignored outside DATA.
- `i_sqi_req` is ignored outside IDLE, including DESEL.
- Latched address and direction do not change mid-transaction.
- Reset asserted mid-transaction:
  - Next cycle: state IDLE, `o_sqi_cs_n` = 1.
  - No DESEL cycle is inserted.
- Bursts have no length limit; the SRAM increments the address internally.

## Configuration
- Macro `IDLI_SQI_WORD_BURST_EN`.
- Defined:
  - DATA ends automatically after exactly 4 nibbles, one 16b word.
  - The 4th nibble is treated as the stop; `i_sqi_stop` is ignored.
  - The DATA counter is 2b.
- Undefined: DATA ends only on `i_sqi_stop`.

## Test plan
- Reset: hold `i_sqi_rst_n` = 0 for 2 cycles -> `o_sqi_cs_n` = 1, all other outputs 0.
- Read at addr 16'h1234, stop on the 4th data cycle, SIO returns 4'hA,4'hB,4'hC,4'hD -> SIO carries 0,3,0,0,1,2,3,4 with `o_sqi_sio_oe` = 1 in cycles 1–8; `o_sqi_sio_oe` = 0 in cycles 9–14; `o_sqi_rd_vld` = 1 with data A,B,C,D in cycles 11–14; `o_sqi_cs_n` = 1 in cycle 15.
- Write at addr 16'hFFFE, data 4'h5 for 2 nibbles, stop on the 2nd -> SIO carries 0,2,0,0,F,F,F,E then 5,5; `o_sqi_wr_rdy` = 1 in cycles 9–10 only; DESEL in cycle 11.
- Back-to-back: `i_sqi_req` held high across a stop -> `o_sqi_ack` low in DESEL; next ack exactly 2 cycles after the stop cycle.
- Reset asserted in cycle 5 of a read -> cycle 6 has `o_sqi_cs_n` = 1 and `o_sqi_sck_en` = 0; the next request restarts at INSTR.
- With `IDLI_SQI_WORD_BURST_EN`: read with `i_sqi_stop` tied 0 -> exactly 4 `o_sqi_rd_vld` cycles, then DESEL. Without the macro, same stimulus -> burst continues past 8 nibbles.
